mul_share_arbiter: RTL

MUL_SHARE_ARBITER -- requirements
Module: mul_share_arbiter

---
 rtl/mul_share_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mul_share_arbiter.sv
// Shares one pipelined fixed-point multiplier among N_REQ requesters.
// Round-robin grant with burst hold; a tag pipeline routes each product back.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   req_valid/req_ready  per-requester handshake (req_ready is one-hot)
//   req_a, req_b         packed signed operands, requester i at [i*WIDTH +: WIDTH]
//   mul_a, mul_b         operands to the shared multiplier (0 when idle)
//   mul_result           multiplier output, MUL_LAT cycles after its operands
//   resp_valid/resp_data one-hot result strobe and product (0 when idle)
//   busy                 high while any issued request is still in flight
module mul_share_arbiter #(
    parameter int WIDTH     = 14,
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 4,
    parameter int MUL_LAT   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       req_ready,
    output logic [WIDTH-1:0]       mul_a,
    output logic [WIDTH-1:0]       mul_b,
    input  logic [WIDTH-1:0]       mul_result,
    output logic [N_REQ-1:0]       resp_valid,
    output logic [WIDTH-1:0]       resp_data,
    output logic                   busy
);

    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef logic [IDW-1:0] id_t;
    typedef logic [3:0]     cnt_t;

    localparam cnt_t MAXB = cnt_t'(MAX_BURST);
    localparam id_t  LAST = id_t'(N_REQ - 1);

    id_t  rr_ptr;
    id_t  last_id;
    cnt_t burst_cnt;

    logic [MUL_LAT-1:0] tag_v;
    id_t                tag_id [MUL_LAT];

    logic xfer;
    logic hold;
    logic others;
    logic rr_found;
    id_t  rr_id;
    id_t  gnt_id;
    cnt_t cnt_next;
    id_t  ptr_next;

    // Round-robin search from rr_ptr, wrapping at N_REQ-1.
    always_comb begin
        rr_found = 1'b0;
        rr_id    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            int idx;
            idx = int'(rr_ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!rr_found && req_valid[idx[IDW-1:0]]) begin
                rr_found = 1'b1;
                rr_id    = idx[IDW-1:0];
            end
        end
    end

    // Burst hold keeps the last winner until MAX_BURST, unless nobody
    // else is waiting, in which case it keeps the grant indefinitely.
    always_comb begin
        others = 1'b0;
        for (int j = 0; j < N_REQ; j++) begin
            if (j != int'(last_id) && req_valid[j]) others = 1'b1;
        end
        hold   = req_valid[last_id] && ((burst_cnt < MAXB) || !others);
        gnt_id = hold ? last_id : rr_id;
        xfer   = !rst && (hold || rr_found);
        if (!hold) begin
            cnt_next = cnt_t'(1);
        end else if (burst_cnt < MAXB) begin
            cnt_next = burst_cnt + cnt_t'(1);
        end else begin
            cnt_next = burst_cnt;
        end
        ptr_next = (gnt_id == LAST) ? '0 : gnt_id + id_t'(1);
    end

    always_comb begin
        req_ready = '0;
        mul_a     = '0;
        mul_b     = '0;
        if (xfer) begin
            req_ready[gnt_id] = 1'b1;
            mul_a = req_a[int'(gnt_id)*WIDTH +: WIDTH];
            mul_b = req_b[int'(gnt_id)*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= '0;
            last_id   <= '0;
            burst_cnt <= '0;
        end else if (xfer) begin
            rr_ptr    <= ptr_next;
            last_id   <= gnt_id;
            burst_cnt <= cnt_next;
        end
    end

    // Tag pipeline mirrors the multiplier latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_v <= '0;
            for (int i = 0; i < MUL_LAT; i++) tag_id[i] <= '0;
        end else begin
            tag_v[0]  <= xfer;
            tag_id[0] <= gnt_id;
            for (int i = 1; i < MUL_LAT; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    always_comb begin
        resp_valid = '0;
        resp_data  = '0;
        if (!rst && tag_v[MUL_LAT-1]) begin
            resp_valid[tag_id[MUL_LAT-1]] = 1'b1;
            resp_data = mul_result;
        end
    end

    assign busy = !rst && (|tag_v);

endmodule
